// File: rtl/pcm_rxd_sync.sv
// pcm_rxd_sync - receive-side PCM frame synchronizer.
//
// Samples the decoded PCM line (clock/data pair) into the clk_i domain, hunts
// for the programmed sync code, verifies it over VERIFY_N further frames and,
// once locked, delivers payload bytes with a frame-start marker. Lock is
// dropped after LOSE_N consecutive missed sync words (flywheeling meanwhile).
//
// Configuration macro: PCM_SYNC_TOL_EN - when defined, a sync word with at
// most one bit error is accepted while in LOCK (HUNT/CHECK stay exact).
//
// Ports:
//   clk_i, rst_n_i       main clock, async active-low reset
//   enable_i             0 forces HUNT and clears frame counters
//   pcm_clk_i/pcm_data_i asynchronous PCM line clock / data
//   edge_i               0 = sample on rising pcm_clk_i, 1 = falling
//   code_i               sync code, right-aligned
//   number_i             sync length select (0/3:4 bytes, 1:3, 2:2)
//   length_i             frame length in bytes, sync included
//   byte_o/byte_vld_o    payload byte + one-cycle strobe (LOCK only)
//   frame_start_o        marks first payload byte of a frame
//   lock_o               high while in LOCK
//   frame_cnt_o          sync words accepted in LOCK (wraps)
module pcm_rxd_sync #(
  parameter int VERIFY_N = 2,
  parameter int LOSE_N   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        pcm_clk_i,
  input  logic        pcm_data_i,
  input  logic        edge_i,
  input  logic [31:0] code_i,
  input  logic [1:0]  number_i,
  input  logic [15:0] length_i,
  output logic [7:0]  byte_o,
  output logic        byte_vld_o,
  output logic        frame_start_o,
  output logic        lock_o,
  output logic [31:0] frame_cnt_o
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  localparam logic [3:0] VN = 4'(VERIFY_N);
  localparam logic [3:0] LN = 4'(LOSE_N);

  state_t      state;
  logic [1:0]  pclk_s, pdat_s;
  logic        pclk_d;
  logic [31:0] sr;
  logic [4:0]  bit_cnt;
  logic [15:0] byte_cnt;
  logic        in_sync;
  logic [3:0]  vcnt, mcnt;

  logic        sample;
  logic [31:0] sr_nxt, mask, diff;
  logic [2:0]  nsync;
  logic [4:0]  sync_last;
  logic [15:0] pay_len;
  logic        frame_ok, exact, near, lock_match;

  // Edge detect and data both taken from the second sync stage so each line
  // bit produces exactly one sample event.
  assign sample = edge_i ? (pclk_d & ~pclk_s[1]) : (~pclk_d & pclk_s[1]);
  assign sr_nxt = {sr[30:0], pdat_s[1]};

  always_comb begin
    nsync     = 3'd4;
    mask      = 32'hFFFF_FFFF;
    sync_last = 5'd31;
    case (number_i)
      2'd1: begin nsync = 3'd3; mask = 32'h00FF_FFFF; sync_last = 5'd23; end
      2'd2: begin nsync = 3'd2; mask = 32'h0000_FFFF; sync_last = 5'd15; end
      default: ;
    endcase
  end

  assign pay_len  = length_i - 16'(nsync);
  assign frame_ok = length_i > 16'(nsync);
  assign diff     = (sr_nxt ^ code_i) & mask;
  assign exact    = (diff == 32'd0);
  // Zero or a single set bit: at most one bit differs.
  assign near     = ((diff & (diff - 32'd1)) == 32'd0);

`ifdef PCM_SYNC_TOL_EN
  assign lock_match = near;
`else
  assign lock_match = exact;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pclk_s        <= '0;
      pdat_s        <= '0;
      pclk_d        <= 1'b0;
      sr            <= '0;
      state         <= HUNT;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      in_sync       <= 1'b0;
      vcnt          <= '0;
      mcnt          <= '0;
      byte_o        <= '0;
      byte_vld_o    <= 1'b0;
      frame_start_o <= 1'b0;
      lock_o        <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      pclk_s        <= {pclk_s[0], pcm_clk_i};
      pdat_s        <= {pdat_s[0], pcm_data_i};
      pclk_d        <= pclk_s[1];
      byte_vld_o    <= 1'b0;
      frame_start_o <= 1'b0;
      if (sample) sr <= sr_nxt;

      if (!enable_i) begin
        state    <= HUNT;
        lock_o   <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        in_sync  <= 1'b0;
        vcnt     <= '0;
        mcnt     <= '0;
      end else if (sample) begin
        case (state)
          HUNT: begin
            if (frame_ok && exact) begin
              state    <= CHECK;
              bit_cnt  <= '0;
              byte_cnt <= pay_len;
              in_sync  <= 1'b0;
              vcnt     <= '0;
            end
          end
          default: begin
            if (!in_sync) begin
              // Payload phase: one byte per 8 samples.
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt - 16'd1;
                if (byte_cnt == 16'd1) in_sync <= 1'b1;
                if (state == LOCK) begin
                  byte_o        <= sr_nxt[7:0];
                  byte_vld_o    <= 1'b1;
                  frame_start_o <= (byte_cnt == pay_len);
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (bit_cnt != sync_last) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else begin
              // Last sync bit: window now holds the whole sync word.
              bit_cnt  <= '0;
              in_sync  <= 1'b0;
              byte_cnt <= pay_len;
              if (state == CHECK) begin
                if (exact) begin
                  if (vcnt + 4'd1 == VN) begin
                    state  <= LOCK;
                    lock_o <= 1'b1;
                    vcnt   <= '0;
                    mcnt   <= '0;
                  end else begin
                    vcnt <= vcnt + 4'd1;
                  end
                end else begin
                  state <= HUNT;
                  vcnt  <= '0;
                end
              end else if (lock_match) begin
                frame_cnt_o <= frame_cnt_o + 32'd1;
                mcnt        <= '0;
              end else if (mcnt + 4'd1 == LN) begin
                state  <= HUNT;
                lock_o <= 1'b0;
                mcnt   <= '0;
              end else begin
                mcnt <= mcnt + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
